vx_mem_req_arb: RTL
===================

Name: vx_mem_req_arb

Overview:
- Parametrised N-to-1 arbiter for memory request channels (valid/rw/byteen/addr/data/tag/ready bundle).
- Merges NUM_REQS requester channels onto one downstream memory request port using round-robin arbitration.
- Appends the winning channel index to the outgoing tag so the response path can route replies back.
- Registers the output through a 2-entry elastic buffer for full throughput and timing isolation. Sits between per-core or per-bank request sources and the shared cache/memory port.

Parameters:
- NUM_REQS, 4, number of input request channels (>=1)
- DATA_WIDTH, 64, request data width in bits (multiple of 8)
- ADDR_WIDTH, 32, request address width
- TAG_WIDTH, 8, input tag width
- DATA_SIZE, DATA_WIDTH/8, byte-enable width (derived)
- LOG_NUM_REQS, clog2(NUM_REQS), index width; 0 when NUM_REQS==1 (derived)
- TAG_OUT_WIDTH, TAG_WIDTH+LOG_NUM_REQS, output tag width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid_in  in  NUM_REQS  per-channel request valid
- req_rw_in  in  NUM_REQS  per-channel write(1)/read(0)
- req_byteen_in  in  NUM_REQS*DATA_SIZE  per-channel byte enables, channel i at slice i
- req_addr_in  in  NUM_REQS*ADDR_WIDTH  per-channel address
- req_data_in  in  NUM_REQS*DATA_WIDTH  per-channel write data
- req_tag_in  in  NUM_REQS*TAG_WIDTH  per-channel tag
- req_ready_in  out  NUM_REQS  per-channel ready
- req_valid_out  out  1  merged request valid
- req_rw_out  out  1  merged rw
- req_byteen_out  out  DATA_SIZE  merged byte enables
- req_addr_out  out  ADDR_WIDTH  merged address
- req_data_out  out  DATA_WIDTH  merged data
- req_tag_out  out  TAG_OUT_WIDTH  {tag_in, channel index}, index in LSBs
- req_ready_out  in  1  downstream ready

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Handshake: transfer occurs when valid && ready in the same cycle on either side. Inputs must hold payload stable while valid && !ready. req_ready_in[i] may depend combinationally on req_valid_in; req_valid_out never depends combinationally on inputs.
- Arbitration:
  - Round-robin pointer rr_ptr (LOG_NUM_REQS bits).
  - Winner = first asserted req_valid_in scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQS.
  - req_ready_in[winner] = buf_can_accept; all other ready bits are 0.
  - On accepted transfer, rr_ptr <= winner+1 (wraps to 0 after NUM_REQS-1).
  - No accepted transfer: rr_ptr holds. A stalled winner keeps the grant, so payload is not lost.
- Output buffer: 2-entry FIFO (skid).
  - buf_can_accept = (count<2), registered-ready style: ready is computed from current count only.
  - Enqueue and dequeue in the same cycle with count==2: no enqueue, because ready was 0.
  - Enqueue and dequeue in the same cycle with count==1: count stays 1.
  - Latency: 1 cycle from input acceptance to req_valid_out when the buffer is empty.
  - Throughput: 1 request/cycle with steady req_ready_out=1.
  - Output order equals acceptance order.
- Tag: req_tag_out = {req_tag_in[winner], winner[LOG_NUM_REQS-1:0]}. When NUM_REQS==1, req_tag_out = req_tag_in, there is no rr_ptr, and the block is a buffered pass-through.
- Reset values: req_valid_out=0, count=0, rr_ptr=0, FIFO pointers=0; payload outputs are don't-care but driven from buffer storage (no X gating required).
- Reset mid-operation: buffered requests are discarded; no input is acked during the reset cycle (req_ready_in=0 while reset is high).
- Boundary: all valids low → no grant, rr_ptr holds; only one valid → it wins regardless of rr_ptr.

Decomposition:
- Shared package vx_mem_pkg:
  - localparam helpers for LOG_NUM_REQS/TAG_OUT_WIDTH computation (clog2 with a 1→0 rule)
  - packed struct mem_req_t {rw, byteen, addr, data, tag} parameterised by widths via macros.
- Sub-module vx_rr_arbiter: NUM_REQS request vector in, one-hot grant + index out, advance input.
- The elastic buffer is inline, or the existing skid buffer is reused if its width is parameterisable.

Test Plan:
- NUM_REQS=4, all 4 valid continuously, req_ready_out=1 → outputs granted in order ch0,1,2,3,0; req_tag_out LSBs 00,01,10,11,00; one output per cycle after 1-cycle latency.
- Only ch2 valid, rr_ptr=3 → ch2 granted next cycle; rr_ptr becomes 3; tag_out = {tag2, 2'b10}.
- req_ready_out=0 for 5 cycles with ch0, ch1 valid → exactly 2 requests accepted (count=2), then all req_ready_in=0. Release → ch0 then ch1 emerge intact, addr/data/byteen bit-exact.
- Same-cycle enqueue/dequeue at count==1, alternating ready 1/0 → no drops, no duplicates; scoreboard matches 100 random requests.
- Assert reset for 1 cycle while count==2 → next cycle req_valid_out=0, rr_ptr=0; a subsequent ch1 request emerges with tag LSBs 01.
- NUM_REQS=1, TAG_WIDTH=8: tag 0xA5 in → req_tag_out=0xA5 (8 bits), 1-cycle latency, back-to-back throughput.

Source files
------------

// File: rtl/vx_mem_pkg.sv
// Shared definitions for the memory request arbiter: index-width helpers and
// the request payload struct shape, which is parameterised through a macro.
`ifndef VX_MEM_PKG_SV
`define VX_MEM_PKG_SV

`define VX_MEM_REQ_T(ds, aw, dw, tw) \
  struct packed { \
    logic            rw; \
    logic [(ds)-1:0] byteen; \
    logic [(aw)-1:0] addr; \
    logic [(dw)-1:0] data; \
    logic [(tw)-1:0] tag; \
  }

package vx_mem_pkg;

  // A single channel needs no index bits.
  function automatic int unsigned log_num_reqs(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  function automatic int unsigned tag_out_width(input int unsigned tag_w, input int unsigned n);
    return tag_w + log_num_reqs(n);
  endfunction

endpackage

`endif

// File: rtl/vx_mem_req_arb_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer wins;
// the pointer moves past the winner only when the grant is consumed.
module vx_rr_arbiter
  import vx_mem_pkg::*;
#(
  parameter int unsigned NUM_REQS     = 4,
  parameter int unsigned LOG_NUM_REQS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQS-1:0]     requests,
  input  logic                    advance,
  output logic                    grant_valid,
  output logic [NUM_REQS-1:0]     grant_onehot,
  output logic [LOG_NUM_REQS-1:0] grant_index
);

  logic [LOG_NUM_REQS-1:0] rr_ptr_q, rr_ptr_d;
  logic [LOG_NUM_REQS:0]   scan_sum;
  logic [LOG_NUM_REQS-1:0] scan_idx;

  always_comb begin
    grant_valid  = 1'b0;
    grant_onehot = '0;
    grant_index  = '0;
    scan_sum     = '0;
    scan_idx     = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      // Modulo wrap without a divider; NUM_REQS need not be a power of two.
      scan_sum = {1'b0, rr_ptr_q} + (LOG_NUM_REQS+1)'(i);
      if (scan_sum >= (LOG_NUM_REQS+1)'(NUM_REQS))
        scan_sum = scan_sum - (LOG_NUM_REQS+1)'(NUM_REQS);
      scan_idx = scan_sum[LOG_NUM_REQS-1:0];
      if (!grant_valid && requests[scan_idx]) begin
        grant_valid            = 1'b1;
        grant_index            = scan_idx;
        grant_onehot[scan_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && grant_valid) begin
      if (grant_index == LOG_NUM_REQS'(NUM_REQS - 1))
        rr_ptr_d = '0;
      else
        rr_ptr_d = grant_index + LOG_NUM_REQS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/vx_mem_req_arb.sv
// N-to-1 memory request arbiter: round-robin select, channel index appended to
// the tag, output registered through a 2-entry elastic buffer.
module vx_mem_req_arb
  import vx_mem_pkg::*;
#(
  parameter  int unsigned NUM_REQS      = 4,
  parameter  int unsigned DATA_WIDTH    = 64,
  parameter  int unsigned ADDR_WIDTH    = 32,
  parameter  int unsigned TAG_WIDTH     = 8,
  localparam int unsigned DATA_SIZE     = DATA_WIDTH / 8,
  localparam int unsigned LOG_NUM_REQS  = log_num_reqs(NUM_REQS),
  localparam int unsigned TAG_OUT_WIDTH = tag_out_width(TAG_WIDTH, NUM_REQS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid_in,
  input  logic [NUM_REQS-1:0]              req_rw_in,
  input  logic [NUM_REQS*DATA_SIZE-1:0]    req_byteen_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]    req_tag_in,
  output logic [NUM_REQS-1:0]              req_ready_in,
  output logic                             req_valid_out,
  output logic                             req_rw_out,
  output logic [DATA_SIZE-1:0]             req_byteen_out,
  output logic [ADDR_WIDTH-1:0]            req_addr_out,
  output logic [DATA_WIDTH-1:0]            req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]         req_tag_out,
  input  logic                             req_ready_out
);

  typedef `VX_MEM_REQ_T(DATA_SIZE, ADDR_WIDTH, DATA_WIDTH, TAG_OUT_WIDTH) mem_req_t;

  logic                     grant_valid;
  logic [NUM_REQS-1:0]      grant_onehot;
  logic [TAG_WIDTH-1:0]     tag_raw;
  logic [TAG_OUT_WIDTH-1:0] sel_tag;
  logic                     buf_can_accept;
  logic                     enq, deq;
  mem_req_t                 req_sel;

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  mem_req_t   mem_q [0:1];
  mem_req_t   mem_d [0:1];

  if (NUM_REQS > 1) begin : g_arb
    logic [LOG_NUM_REQS-1:0] grant_idx;

    vx_rr_arbiter #(
      .NUM_REQS     (NUM_REQS),
      .LOG_NUM_REQS (LOG_NUM_REQS)
    ) u_arb (
      .clk          (clk),
      .reset        (reset),
      .requests     (req_valid_in),
      .advance      (enq),
      .grant_valid  (grant_valid),
      .grant_onehot (grant_onehot),
      .grant_index  (grant_idx)
    );

    assign sel_tag = {tag_raw, grant_idx};
  end else begin : g_pass
    assign grant_valid  = req_valid_in[0];
    assign grant_onehot = req_valid_in;
    assign sel_tag      = tag_raw;
  end

  // One-hot AND-OR payload mux keyed off the arbiter grant.
  always_comb begin
    req_sel        = '0;
    tag_raw        = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (grant_onehot[i]) begin
        req_sel.rw     = req_rw_in[i];
        req_sel.byteen = req_byteen_in[i*DATA_SIZE +: DATA_SIZE];
        req_sel.addr   = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        req_sel.data   = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        tag_raw        = req_tag_in[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
    req_sel.tag = sel_tag;
  end

  // Ready depends only on the current occupancy, never on downstream ready.
  assign buf_can_accept = (count_q != 2'd2) && !reset;
  assign req_ready_in   = grant_onehot & {NUM_REQS{buf_can_accept}};
  assign enq            = grant_valid && buf_can_accept;
  assign deq            = (count_q != 2'd0) && req_ready_out;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, enq} - {1'b0, deq};
    if (enq) begin
      mem_d[wr_ptr_q] = req_sel;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (deq) rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign req_valid_out  = (count_q != 2'd0);
  assign req_rw_out     = mem_q[rd_ptr_q].rw;
  assign req_byteen_out = mem_q[rd_ptr_q].byteen;
  assign req_addr_out   = mem_q[rd_ptr_q].addr;
  assign req_data_out   = mem_q[rd_ptr_q].data;
  assign req_tag_out    = mem_q[rd_ptr_q].tag;

endmodule
